// File: rtl/ap_ctrl_txn_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : ap_ctrl_txn_monitor
//  Description : Per-channel ap_ctrl handshake monitor. Records a timestamp
//                per accepted start in a small FIFO, and on each completion
//                updates transaction count, last/min/max latency and sticky
//                overflow/underflow flags. Statistics for one channel are
//                read out through a registered channel-select port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ap_ctrl_txn_monitor #(
   parameter int  NUM_CH   = 4,
   parameter int  INFLIGHT = 4,
   parameter int  TS_W     = 16,
   parameter int  CNT_W    = 32,
   localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int PTR_W    = $clog2(INFLIGHT) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              finish,
   input  logic              clear,
   input  logic [NUM_CH-1:0] ch_start,
   input  logic [NUM_CH-1:0] ch_ready,
   input  logic [NUM_CH-1:0] ch_done,
   input  logic [NUM_CH-1:0] ch_continue,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic              rd_valid,
   output logic [CNT_W-1:0]  rd_txn_cnt,
   output logic [TS_W-1:0]   rd_last_lat,
   output logic [TS_W-1:0]   rd_min_lat,
   output logic [TS_W-1:0]   rd_max_lat,
   output logic [PTR_W-1:0]  rd_inflight,
   output logic              rd_ovf,
   output logic              rd_unf,
   output logic              any_err
);

   localparam logic [PTR_W-1:0] c_depth  = PTR_W'(INFLIGHT);
   localparam logic [SEL_W:0]   c_num_ch = (SEL_W + 1)'(NUM_CH);

   logic [TS_W-1:0]  r_ts;

   // Post-update view of every channel, muxed into the readout registers
   logic [CNT_W-1:0] w_nx_cnt   [NUM_CH];
   logic [TS_W-1:0]  w_nx_last  [NUM_CH];
   logic [TS_W-1:0]  w_nx_min   [NUM_CH];
   logic [TS_W-1:0]  w_nx_max   [NUM_CH];
   logic [PTR_W-1:0] w_nx_depth [NUM_CH];
   logic [NUM_CH-1:0] w_nx_ovf;
   logic [NUM_CH-1:0] w_nx_unf;
   logic [NUM_CH-1:0] w_err;

   logic             r_rd_valid, r_rd_ovf, r_rd_unf, r_any_err;
   logic [CNT_W-1:0] r_rd_cnt;
   logic [TS_W-1:0]  r_rd_last, r_rd_min, r_rd_max;
   logic [PTR_W-1:0] r_rd_depth;

   // Free-running timestamp, frozen while the simulation is finishing
   always_ff @(posedge clock or posedge reset) begin
      if (reset)        r_ts <= '0;
      else if (!finish) r_ts <= r_ts + TS_W'(1);
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [TS_W-1:0]  r_fifo [INFLIGHT];
      logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_n, w_rd_ptr_n, w_depth;
      logic [CNT_W-1:0] r_cnt, w_cnt_n;
      logic [TS_W-1:0]  r_last, r_min, r_max, w_last_n, w_min_n, w_max_n;
      logic [TS_W-1:0]  w_head, w_lat, w_done_lat;
      logic             r_ovf, r_unf, w_ovf_n, w_unf_n;
      logic             w_push, w_pop, w_empty, w_full, w_wr_en, w_done;

      assign w_push  = ch_start[c] & ch_ready[c];
      assign w_pop   = ch_done[c] & ch_continue[c];
      assign w_depth = r_wr_ptr - r_rd_ptr;
      assign w_empty = (w_depth == '0);
      assign w_full  = (w_depth == c_depth);
      assign w_head  = r_fifo[r_rd_ptr[PTR_W-2:0]];
      assign w_lat   = r_ts - w_head;

      // Next-state: clear wins; an empty-FIFO pop is legal only when a start
      // arrives in the same cycle (zero-latency pass-through)
      always_comb begin
         w_wr_ptr_n = r_wr_ptr;
         w_rd_ptr_n = r_rd_ptr;
         w_cnt_n    = r_cnt;
         w_last_n   = r_last;
         w_min_n    = r_min;
         w_max_n    = r_max;
         w_ovf_n    = r_ovf;
         w_unf_n    = r_unf;
         w_wr_en    = 1'b0;
         w_done     = 1'b0;
         w_done_lat = '0;
         if (!finish) begin
            if (clear) begin
               w_wr_ptr_n = '0;
               w_rd_ptr_n = '0;
               w_cnt_n    = '0;
               w_last_n   = '0;
               w_min_n    = '1;
               w_max_n    = '0;
               w_ovf_n    = 1'b0;
               w_unf_n    = 1'b0;
            end else begin
               if (w_pop && w_empty) begin
                  if (w_push) w_done  = 1'b1;
                  else        w_unf_n = 1'b1;
               end else begin
                  if (w_pop) begin
                     w_done     = 1'b1;
                     w_done_lat = w_lat;
                     w_rd_ptr_n = r_rd_ptr + PTR_W'(1);
                  end
                  if (w_push) begin
                     if (w_full && !w_pop) begin
                        w_ovf_n = 1'b1;
                     end else begin
                        w_wr_en    = 1'b1;
                        w_wr_ptr_n = r_wr_ptr + PTR_W'(1);
                     end
                  end
               end
               if (w_done) begin
                  if (r_cnt != '1) w_cnt_n = r_cnt + CNT_W'(1);
                  w_last_n = w_done_lat;
                  if (w_done_lat < r_min) w_min_n = w_done_lat;
                  if (w_done_lat > r_max) w_max_n = w_done_lat;
               end
            end
         end
      end

      // Channel state registers
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_last   <= '0;
            r_min    <= '1;
            r_max    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
         end else begin
            r_wr_ptr <= w_wr_ptr_n;
            r_rd_ptr <= w_rd_ptr_n;
            r_cnt    <= w_cnt_n;
            r_last   <= w_last_n;
            r_min    <= w_min_n;
            r_max    <= w_max_n;
            r_ovf    <= w_ovf_n;
            r_unf    <= w_unf_n;
         end
      end

      // Timestamp storage; contents are only meaningful between the pointers
      always_ff @(posedge clock) begin
         if (w_wr_en) r_fifo[r_wr_ptr[PTR_W-2:0]] <= r_ts;
      end

      assign w_nx_cnt[c]   = w_cnt_n;
      assign w_nx_last[c]  = w_last_n;
      assign w_nx_min[c]   = w_min_n;
      assign w_nx_max[c]   = w_max_n;
      assign w_nx_depth[c] = w_wr_ptr_n - w_rd_ptr_n;
      assign w_nx_ovf[c]   = w_ovf_n;
      assign w_nx_unf[c]   = w_unf_n;
      assign w_err[c]      = r_ovf | r_unf;
   end

   // Readout registers capture the selected channel as updated by this edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_cnt   <= '0;
         r_rd_last  <= '0;
         r_rd_min   <= '0;
         r_rd_max   <= '0;
         r_rd_depth <= '0;
         r_rd_ovf   <= 1'b0;
         r_rd_unf   <= 1'b0;
      end else if ({1'b0, rd_sel} < c_num_ch) begin
         r_rd_valid <= 1'b1;
         r_rd_cnt   <= w_nx_cnt[rd_sel];
         r_rd_last  <= w_nx_last[rd_sel];
         r_rd_min   <= w_nx_min[rd_sel];
         r_rd_max   <= w_nx_max[rd_sel];
         r_rd_depth <= w_nx_depth[rd_sel];
         r_rd_ovf   <= w_nx_ovf[rd_sel];
         r_rd_unf   <= w_nx_unf[rd_sel];
      end else begin
         r_rd_valid <= 1'b0;
         r_rd_cnt   <= '0;
         r_rd_last  <= '0;
         r_rd_min   <= '0;
         r_rd_max   <= '0;
         r_rd_depth <= '0;
         r_rd_ovf   <= 1'b0;
         r_rd_unf   <= 1'b0;
      end
   end

   // Global error summary, one cycle behind the sticky flags
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_any_err <= 1'b0;
      else       r_any_err <= |w_err;
   end

   assign rd_valid    = r_rd_valid;
   assign rd_txn_cnt  = r_rd_cnt;
   assign rd_last_lat = r_rd_last;
   assign rd_min_lat  = r_rd_min;
   assign rd_max_lat  = r_rd_max;
   assign rd_inflight = r_rd_depth;
   assign rd_ovf      = r_rd_ovf;
   assign rd_unf      = r_rd_unf;
   assign any_err     = r_any_err;

endmodule
`default_nettype wire
